// File: rtl/pkt_chan_arbiter.sv
// Packet-granular round-robin arbiter sharing one head/data/tail channel among NREQ requesters.
// The owner holds the channel from grant until its tail; framing violations and grant timeouts pulse flags.
module pkt_chan_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] head,
  input  logic [NREQ-1:0] tail,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] gnt,
  output logic            out_head,
  output logic            out_tail,
  output logic            out_valid,
  output logic            busy,
  output logic            proto_err,
  output logic            timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    DATA = 2'b10,
    TAIL = 2'b11
  } state_t;

  state_t          state;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   ptr;
  logic [7:0]      timer;

  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   start;
  logic [IW-1:0]   pick;
  logic            found;
  logic [NREQ-1:0] gnt_next;
  int              idx;

  logic            beat;
  logic            beat_head;
  logic            beat_tail;
  logic            drop;

  assign beat      = valid[winner] & gnt[winner];
  assign beat_head = head[winner];
  assign beat_tail = tail[winner];

  // In TAIL the pointer update is still in flight, so search from winner+1 directly.
  assign next_ptr = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
  assign start    = (state == TAIL) ? next_ptr : ptr;

  always_comb begin
    found = 1'b0;
    pick  = start;
    idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign gnt_next = NREQ'(1) << pick;

  // A headless beat in HEAD is dropped; a head marker inside DATA is stripped.
  assign drop      = (state == HEAD) & beat & ~beat_head;
  assign out_valid = (|(gnt & valid)) & ~drop;
  assign out_head  = (|(gnt & head)) & ~((state == DATA) & beat);
  assign out_tail  = |(gnt & tail);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      winner      <= '0;
      ptr         <= '0;
      timer       <= '0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE, TAIL: begin
          if (state == TAIL) ptr <= next_ptr;
          if (found) begin
            gnt    <= gnt_next;
            winner <= pick;
            timer  <= '0;
            state  <= HEAD;
          end else begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
        HEAD: begin
          if (beat && beat_head) begin
            if (beat_tail) begin
              state <= TAIL;
              gnt   <= '0;
            end else begin
              state <= DATA;
            end
          end else begin
            if (beat) proto_err <= 1'b1;
            if (!beat && !req[winner]) begin
              state <= TAIL;
              gnt   <= '0;
            end else if (timer == 8'(TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              state       <= TAIL;
              gnt         <= '0;
            end else begin
              timer <= timer + 8'd1;
            end
          end
        end
        DATA: begin
          if (beat) begin
            if (beat_head) proto_err <= 1'b1;
            if (beat_tail) begin
              state <= TAIL;
              gnt   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_chan_arbiter.sv
// Scoreboard bench for pkt_chan_arbiter: expected grant order is queued as requests are raised
// and popped as grants appear; channel, error and timing behaviour is checked cycle by cycle.
module tb_pkt_chan_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic            clock = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] head;
  logic [NREQ-1:0] tail;
  logic [NREQ-1:0] valid;
  logic [NREQ-1:0] gnt;
  logic            out_head;
  logic            out_tail;
  logic            out_valid;
  logic            busy;
  logic            proto_err;
  logic            timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_gnt[$];

  pkt_chan_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .head(head), .tail(tail), .valid(valid),
    .gnt(gnt), .out_head(out_head), .out_tail(out_tail), .out_valid(out_valid),
    .busy(busy), .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Granted requester gets the given beat; everyone else gets random noise.
  task automatic drive_beat(input logic [NREQ-1:0] g, input logic h, input logic t, input logic v);
    valid = (NREQ'($urandom) & ~g) | (v ? g : '0);
    head  = (NREQ'($urandom) & ~g) | (h ? g : '0);
    tail  = (NREQ'($urandom) & ~g) | (t ? g : '0);
  endtask

  task automatic wait_gnt(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; head = '0; tail = '0; valid = '0;
    tick();
    tick();
    n_cmp++;
    if ({gnt, busy, proto_err, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_state: gnt=%b busy=%b perr=%b terr=%b, required all 0", gnt, busy, proto_err, timeout_err);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      drive_beat('0, 1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if ({gnt, busy, out_head, out_tail, out_valid, proto_err, timeout_err} !== '0) begin
        n_err++;
        $display("FAIL idle_quiet cyc%0d: gnt=%b busy=%b out=%b%b%b, required all 0", i, gnt, busy, out_head, out_tail, out_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    logic ok;
    int   e, c0, tcyc;
    tick();
    req = 4'b1111;
    c0 = cyc;
    tcyc = 0;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    exp_gnt.push_back(3); exp_gnt.push_back(0);
    for (int p = 0; p < 5; p++) begin
      wait_gnt(10, ok);
      e = exp_gnt.pop_front();
      n_cmp++;
      if (!ok || gnt !== NREQ'(1) << e) begin
        n_err++;
        $display("FAIL rr_grant p%0d: gnt=%b, required %b", p, gnt, NREQ'(1) << e);
      end
      n_cmp++;
      if ((p == 0 && cyc - c0 != 1) || (p != 0 && cyc - tcyc != 2)) begin
        n_err++;
        $display("FAIL rr_latency p%0d: grant at cycle %0d, req/tail at %0d %0d", p, cyc, c0, tcyc);
      end
      drive_beat(gnt, 1'b1, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if ({out_head, out_tail, out_valid} !== 3'b101) begin
        n_err++;
        $display("FAIL rr_head p%0d: out h/t/v=%b%b%b, required 101", p, out_head, out_tail, out_valid);
      end
      tick();
      drive_beat(NREQ'(1) << e, 1'b0, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if ({out_head, out_tail, out_valid} !== 3'b001 || gnt !== NREQ'(1) << e) begin
        n_err++;
        $display("FAIL rr_data p%0d: out h/t/v=%b%b%b gnt=%b, required 001 %b", p, out_head, out_tail, out_valid, gnt, NREQ'(1) << e);
      end
      tick();
      if (p == 4) req = '0;
      drive_beat(NREQ'(1) << e, 1'b0, 1'b1, 1'b1);
      #1;
      tcyc = cyc;
      n_cmp++;
      if ({out_head, out_tail, out_valid} !== 3'b011) begin
        n_err++;
        $display("FAIL rr_tail p%0d: out h/t/v=%b%b%b, required 011", p, out_head, out_tail, out_valid);
      end
      tick();
      drive_beat('0, 1'b1, 1'b1, 1'b1);
      #1;
      n_cmp++;
      if (gnt !== '0 || busy !== 1'b1 || {out_head, out_tail, out_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL rr_tailstate p%0d: gnt=%b busy=%b out=%b%b%b, required 0 1 000", p, gnt, busy, out_head, out_tail, out_valid);
      end
    end
    tick();
    n_cmp++;
    if (gnt !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rr_end_idle: gnt=%b busy=%b, required 0 0", gnt, busy);
    end
  endtask

  task automatic test_single_beat();
    logic ok;
    int   e, tcyc;
    tick();
    req = 4'b1101;
    tcyc = cyc - 1;
    exp_gnt.push_back(2); exp_gnt.push_back(3); exp_gnt.push_back(0);
    for (int p = 0; p < 3; p++) begin
      wait_gnt(5, ok);
      e = exp_gnt.pop_front();
      n_cmp++;
      if (!ok || gnt !== NREQ'(1) << e || cyc - tcyc != 2) begin
        n_err++;
        $display("FAIL single_grant p%0d: gnt=%b gap=%0d, required %b gap 2", p, gnt, cyc - tcyc, NREQ'(1) << e);
      end
      req = req & ~gnt;
      drive_beat(gnt, 1'b1, 1'b1, 1'b1);
      #1;
      tcyc = cyc;
      n_cmp++;
      if ({out_head, out_tail, out_valid} !== 3'b111) begin
        n_err++;
        $display("FAIL single_beat p%0d: out h/t/v=%b%b%b, required 111", p, out_head, out_tail, out_valid);
      end
      tick();
      drive_beat('0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (gnt !== '0 || busy !== 1'b1 || proto_err !== 1'b0) begin
        n_err++;
        $display("FAIL single_tail p%0d: gnt=%b busy=%b perr=%b, required 0 1 0", p, gnt, busy, proto_err);
      end
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_end_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    int   e;
    tick();
    req = 4'b0010;
    exp_gnt.push_back(1);
    wait_gnt(5, ok);
    e = exp_gnt.pop_front();
    n_cmp++;
    if (!ok || gnt !== NREQ'(1) << e) begin
      n_err++;
      $display("FAIL to_grant: gnt=%b, required %b", gnt, NREQ'(1) << e);
    end
    drive_beat(4'b0010, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      drive_beat(4'b0010, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (gnt !== 4'b0010 || timeout_err !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL to_wait k%0d: gnt=%b terr=%b busy=%b, required 0010 0 1", k, gnt, timeout_err, busy);
      end
    end
    tick();
    n_cmp++;
    if (timeout_err !== 1'b1 || gnt !== '0 || busy !== 1'b1 || proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL to_pulse: terr=%b gnt=%b busy=%b perr=%b, required 1 0 1 0", timeout_err, gnt, busy, proto_err);
    end
    req = 4'b1011;
    exp_gnt.push_back(3);
    tick();
    e = exp_gnt.pop_front();
    n_cmp++;
    if (timeout_err !== 1'b0 || gnt !== NREQ'(1) << e) begin
      n_err++;
      $display("FAIL to_after: terr=%b gnt=%b, required 0 %b", timeout_err, gnt, NREQ'(1) << e);
    end
    req = '0;
    drive_beat(gnt, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (gnt !== '0 || busy !== 1'b1 || proto_err !== 1'b0 || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL abandon: gnt=%b busy=%b perr=%b terr=%b, required 0 1 0 0", gnt, busy, proto_err, timeout_err);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || proto_err !== 1'b0 || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL abandon_idle: busy=%b perr=%b terr=%b, required 0 0 0", busy, proto_err, timeout_err);
    end
  endtask

  task automatic test_proto_err();
    logic ok;
    int   e;
    tick();
    req = 4'b0001;
    exp_gnt.push_back(0);
    wait_gnt(5, ok);
    e = exp_gnt.pop_front();
    n_cmp++;
    if (!ok || gnt !== NREQ'(1) << e) begin
      n_err++;
      $display("FAIL pe_grant: gnt=%b, required %b", gnt, NREQ'(1) << e);
    end
    drive_beat(4'b0001, 1'b0, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if ({out_head, out_tail, out_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL pe_drop: out h/t/v=%b%b%b, required 000", out_head, out_tail, out_valid);
    end
    tick();
    n_cmp++;
    if (proto_err !== 1'b1 || gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL pe_head_pulse: perr=%b gnt=%b, required 1 0001", proto_err, gnt);
    end
    drive_beat(4'b0001, 1'b1, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if ({out_head, out_tail, out_valid} !== 3'b101) begin
      n_err++;
      $display("FAIL pe_head_ok: out h/t/v=%b%b%b, required 101", out_head, out_tail, out_valid);
    end
    tick();
    drive_beat(4'b0001, 1'b1, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (proto_err !== 1'b0 || {out_head, out_tail, out_valid} !== 3'b001) begin
      n_err++;
      $display("FAIL pe_data_head: perr=%b out h/t/v=%b%b%b, required 0 001", proto_err, out_head, out_tail, out_valid);
    end
    tick();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL pe_data_pulse: perr=%b, required 1", proto_err);
    end
    req = '0;
    drive_beat(4'b0001, 1'b0, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if ({out_head, out_tail, out_valid} !== 3'b011) begin
      n_err++;
      $display("FAIL pe_tail: out h/t/v=%b%b%b, required 011", out_head, out_tail, out_valid);
    end
    tick();
    n_cmp++;
    if (gnt !== '0 || busy !== 1'b1 || proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL pe_tailstate: gnt=%b busy=%b perr=%b, required 0 1 0", gnt, busy, proto_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic ok;
    int   e, c0;
    tick();
    req = 4'b0010;
    exp_gnt.push_back(1);
    wait_gnt(5, ok);
    e = exp_gnt.pop_front();
    n_cmp++;
    if (!ok || gnt !== NREQ'(1) << e) begin
      n_err++;
      $display("FAIL rm_grant: gnt=%b, required %b", gnt, NREQ'(1) << e);
    end
    drive_beat(gnt, 1'b1, 1'b0, 1'b1);
    tick();
    drive_beat(4'b0010, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_beat('0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({gnt, busy, proto_err, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL rm_abort: gnt=%b busy=%b perr=%b terr=%b, required all 0", gnt, busy, proto_err, timeout_err);
    end
    req = 4'b0101;
    c0 = cyc;
    exp_gnt.push_back(0);
    wait_gnt(3, ok);
    e = exp_gnt.pop_front();
    n_cmp++;
    if (!ok || gnt !== NREQ'(1) << e || cyc - c0 != 1 || proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL rm_ptr_reset: gnt=%b lat=%0d perr=%b, required %b 1 0", gnt, cyc - c0, proto_err, NREQ'(1) << e);
    end
    req = 4'b0100;
    drive_beat(gnt, 1'b0, 1'b0, 1'b0);
    exp_gnt.push_back(2);
    tick();
    tick();
    e = exp_gnt.pop_front();
    n_cmp++;
    if (gnt !== NREQ'(1) << e) begin
      n_err++;
      $display("FAIL rm_next: gnt=%b, required %b", gnt, NREQ'(1) << e);
    end
    req = '0;
    drive_beat(gnt, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || gnt !== '0) begin
      n_err++;
      $display("FAIL rm_end_idle: busy=%b gnt=%b, required 0 0", busy, gnt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_beat();
    test_timeout();
    test_proto_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
